// File: rtl/svc_sim_lifecycle_mon.sv
// Run-lifecycle monitor: classifies a simulation run as PASS/FAIL/TRAP/TIMEOUT and
// raises done only after the UART transmitter has drained.
//   state   | meaning
//   S_IDLE  | waiting for en, outputs cleared
//   S_RUN   | counting cycles, watching events and watchdogs
//   S_DRAIN | result latched, waiting for tx idle or drain cap
//   S_DONE  | result final, held until reset
module svc_sim_lifecycle_mon #(
    parameter int                NUM_CH          = 1,
    parameter int                WATCHDOG_CYCLES = 1_000_000,
    parameter int                CNT_W           = 32,
    parameter int                ADDR_W          = 32,
    parameter int                DATA_W          = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR     = 32'h0000_1000,
    parameter int                DRAIN_CYCLES    = 1024,
    parameter int                DRAIN_MAX       = 65536
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic [NUM_CH-1:0] kick,
    input  logic              halt,
    input  logic              trap,
    input  logic              mmio_wr_valid,
    input  logic [ADDR_W-1:0] mmio_wr_addr,
    input  logic [DATA_W-1:0] mmio_wr_data,
    input  logic              tx_busy,
    output logic              running,
    output logic              done,
    output logic [2:0]        status,
    output logic [DATA_W-2:0] exit_code,
    output logic [NUM_CH-1:0] timeout_ch,
    output logic [CNT_W-1:0]  cycles
);
    localparam logic [2:0] ST_NONE    = 3'd0;
    localparam logic [2:0] ST_PASS    = 3'd1;
    localparam logic [2:0] ST_FAIL    = 3'd2;
    localparam logic [2:0] ST_TRAP    = 3'd3;
    localparam logic [2:0] ST_TIMEOUT = 3'd4;

    localparam int DRAIN_TOP = (DRAIN_CYCLES > DRAIN_MAX) ? DRAIN_CYCLES : DRAIN_MAX;
    localparam int DW        = $clog2(DRAIN_TOP + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  wd_cnt [NUM_CH];
    logic [DW-1:0]     idle_cnt;
    logic [DW-1:0]     drain_cnt;
    logic [NUM_CH-1:0] expire;
    logic              tohost_hit;
    logic              any_event;
    logic [DW-1:0]     idle_nxt;
    logic [DW-1:0]     drain_nxt;

    always_comb begin
        expire = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            expire[i] = ch_en[i] && !kick[i] && (wd_cnt[i] == CNT_W'(WATCHDOG_CYCLES - 1));
        end
    end

    // Only an odd tohost value is an exit request; even values are console traffic.
    assign tohost_hit = mmio_wr_valid && (mmio_wr_addr == TOHOST_ADDR) && mmio_wr_data[0];
    assign any_event  = trap || tohost_hit || halt || (|expire);
    assign idle_nxt   = tx_busy ? '0 : idle_cnt + DW'(1);
    assign drain_nxt  = drain_cnt + DW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            running    <= 1'b0;
            done       <= 1'b0;
            status     <= ST_NONE;
            exit_code  <= '0;
            timeout_ch <= '0;
            cycles     <= '0;
            idle_cnt   <= '0;
            drain_cnt  <= '0;
            for (int i = 0; i < NUM_CH; i++) wd_cnt[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (en) begin
                        state     <= S_RUN;
                        running   <= 1'b1;
                        cycles    <= '0;
                        idle_cnt  <= '0;
                        drain_cnt <= '0;
                        for (int i = 0; i < NUM_CH; i++) wd_cnt[i] <= '0;
                    end
                end
                S_RUN: begin
                    if (cycles != '1) cycles <= cycles + CNT_W'(1);
                    for (int i = 0; i < NUM_CH; i++) begin
                        wd_cnt[i] <= (kick[i] || !ch_en[i]) ? '0 : wd_cnt[i] + CNT_W'(1);
                    end
                    if (trap) begin
                        status    <= ST_TRAP;
                        exit_code <= '0;
                    end else if (tohost_hit) begin
                        exit_code <= mmio_wr_data[DATA_W-1:1];
                        status    <= (mmio_wr_data[DATA_W-1:1] == '0) ? ST_PASS : ST_FAIL;
                    end else if (halt) begin
                        status    <= ST_PASS;
                        exit_code <= '0;
                    end else if (|expire) begin
                        status     <= ST_TIMEOUT;
                        timeout_ch <= expire;
                    end
                    if (any_event) begin
                        state   <= S_DRAIN;
                        running <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    idle_cnt  <= idle_nxt;
                    drain_cnt <= drain_nxt;
                    if ((idle_nxt == DW'(DRAIN_CYCLES)) || (drain_nxt == DW'(DRAIN_MAX))) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_svc_sim_lifecycle_mon.sv
// Bench for svc_sim_lifecycle_mon: directed lifecycles plus random ones, each scored
// against a window/priority model of the run rules.
module tb_svc_sim_lifecycle_mon;
    localparam int NUM_CH = 2;
    localparam int WC     = 16;
    localparam int CNT_W  = 8;
    localparam int DC     = 16;
    localparam int DMAX   = 64;
    localparam int MAXC   = 400;
    localparam logic [31:0] TOHOST = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  ch_en = '0;
    logic [1:0]  kick = '0;
    logic        halt = 1'b0;
    logic        trap = 1'b0;
    logic        mmio_wr_valid = 1'b0;
    logic [31:0] mmio_wr_addr = '0;
    logic [31:0] mmio_wr_data = '0;
    logic        tx_busy = 1'b0;
    logic        running;
    logic        done;
    logic [2:0]  status;
    logic [30:0] exit_code;
    logic [1:0]  timeout_ch;
    logic [7:0]  cycles;

    svc_sim_lifecycle_mon #(
        .NUM_CH(NUM_CH), .WATCHDOG_CYCLES(WC), .CNT_W(CNT_W), .ADDR_W(32), .DATA_W(32),
        .TOHOST_ADDR(TOHOST), .DRAIN_CYCLES(DC), .DRAIN_MAX(DMAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ch_en(ch_en), .kick(kick), .halt(halt),
        .trap(trap), .mmio_wr_valid(mmio_wr_valid), .mmio_wr_addr(mmio_wr_addr),
        .mmio_wr_data(mmio_wr_data), .tx_busy(tx_busy), .running(running), .done(done),
        .status(status), .exit_code(exit_code), .timeout_ch(timeout_ch), .cycles(cycles)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [1:0]  s_chen [MAXC];
    logic [1:0]  s_kick [MAXC];
    bit          s_trap [MAXC];
    bit          s_halt [MAXC];
    bit          s_wr   [MAXC];
    logic [31:0] s_addr [MAXC];
    logic [31:0] s_data [MAXC];
    bit          s_busy [DMAX];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] obs();
        return {18'd0, running, done, status, exit_code, timeout_ch, cycles};
    endfunction

    function automatic logic [63:0] pk(input bit r, input bit d, input logic [2:0] st,
                                       input logic [30:0] ec, input logic [1:0] tc,
                                       input logic [7:0] cy);
        return {18'd0, r, d, st, ec, tc, cy};
    endfunction

    task automatic idle_inputs();
        en = 1'b0; ch_en = '0; kick = '0; halt = 1'b0; trap = 1'b0;
        mmio_wr_valid = 1'b0; mmio_wr_addr = '0; mmio_wr_data = '0; tx_busy = 1'b0;
    endtask

    task automatic clear_stim();
        for (int k = 0; k < MAXC; k++) begin
            s_chen[k] = '0; s_kick[k] = '0; s_trap[k] = 0; s_halt[k] = 0;
            s_wr[k] = 0; s_addr[k] = '0; s_data[k] = '0;
        end
        for (int j = 0; j < DMAX; j++) s_busy[j] = 0;
    endtask

    task automatic gen_random();
        int pb;
        pb = $urandom_range(0, 2);
        for (int k = 0; k < MAXC; k++) begin
            s_chen[k] = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b11;
            s_kick[k] = {($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0)};
            s_trap[k] = ($urandom_range(0, 299) == 0);
            s_halt[k] = ($urandom_range(0, 199) == 0);
            s_wr[k]   = ($urandom_range(0, 29) == 0);
            s_addr[k] = ($urandom_range(0, 1) == 1) ? TOHOST : $urandom;
            s_data[k] = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
        end
        s_halt[MAXC-1] = 1;
        for (int j = 0; j < DMAX; j++) begin
            if (pb == 0)      s_busy[j] = 0;
            else if (pb == 1) s_busy[j] = ($urandom_range(0, 4) == 0);
            else              s_busy[j] = ($urandom_range(0, 19) != 0);
        end
    endtask

    // A channel expires at cycle k when the last WC cycles (k inclusive) were all
    // enabled and unkicked; the first cycle with any event ends RUN.
    task automatic model(output int ke, output logic [2:0] st, output logic [30:0] ec,
                         output logic [1:0] tc, output int jd);
        int idle;
        logic [1:0] exp_ch;
        bit all_q;
        bit hit;
        ke = -1; st = 3'd0; ec = '0; tc = '0;
        for (int k = 0; k < MAXC && ke < 0; k++) begin
            exp_ch = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (k >= WC - 1) begin
                    all_q = 1;
                    for (int m = k - WC + 1; m <= k; m++)
                        if (!s_chen[m][c] || s_kick[m][c]) all_q = 0;
                    exp_ch[c] = all_q;
                end
            end
            hit = s_wr[k] && (s_addr[k] == TOHOST) && s_data[k][0];
            if (s_trap[k]) begin
                st = 3'd3; ke = k;
            end else if (hit) begin
                ec = s_data[k][31:1]; st = (ec == 0) ? 3'd1 : 3'd2; ke = k;
            end else if (s_halt[k]) begin
                st = 3'd1; ke = k;
            end else if (exp_ch != 0) begin
                st = 3'd4; tc = exp_ch; ke = k;
            end
        end
        if (ke < 0) ke = MAXC - 1;
        idle = 0; jd = DMAX;
        for (int j = 0; j < DMAX; j++) begin
            idle = s_busy[j] ? 0 : idle + 1;
            if (idle >= DC) begin
                jd = j + 1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset", obs(), 64'd0);
        rst_n = 1'b1; trap = 1'b1; halt = 1'b1;
        @(negedge clk);
        check("idle_ignore", obs(), 64'd0);
        idle_inputs();
    endtask

    task automatic do_run(input string tag, input int rst_at);
        int ke, jd;
        logic [2:0] st;
        logic [30:0] ec;
        logic [1:0] tc;
        logic [7:0] cy;
        model(ke, st, ec, tc, jd);
        cy = (ke + 1 > 255) ? 8'd255 : 8'(ke + 1);
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        check({tag, " run_entry"}, obs(), pk(1, 0, 3'd0, '0, '0, 8'd0));
        for (int k = 0; k <= ke; k++) begin
            ch_en = s_chen[k]; kick = s_kick[k]; trap = s_trap[k]; halt = s_halt[k];
            mmio_wr_valid = s_wr[k]; mmio_wr_addr = s_addr[k]; mmio_wr_data = s_data[k];
            en = 1'($urandom);
            @(negedge clk);
        end
        check({tag, " event"}, obs(), pk(0, 0, st, ec, tc, cy));
        for (int j = 0; j < jd; j++) begin
            tx_busy = s_busy[j]; trap = 1'($urandom); halt = 1'($urandom);
            mmio_wr_valid = 1'($urandom); mmio_wr_addr = TOHOST; mmio_wr_data = $urandom;
            kick = 2'($urandom); ch_en = 2'($urandom); en = 1'($urandom);
            if (j == rst_at) begin
                #2 rst_n = 1'b0;
                #1 check({tag, " async_reset"}, obs(), 64'd0);
                @(negedge clk);
                check({tag, " reset_no_done"}, obs(), 64'd0);
                rst_n = 1'b1;
                idle_inputs();
                return;
            end
            @(negedge clk);
            check({tag, " drain"}, obs(), pk(0, (j + 1 == jd), st, ec, tc, cy));
        end
        repeat (3) begin
            en = ~en; trap = 1'b1; halt = 1'b1;
            @(negedge clk);
            check({tag, " done_hold"}, obs(), pk(0, 1, st, ec, tc, cy));
        end
        idle_inputs();
    endtask

    initial begin
        do_reset();

        clear_stim();
        s_wr[100] = 1; s_addr[100] = TOHOST; s_data[100] = 32'h1;
        do_run("clean", -1);

        do_reset(); clear_stim();
        s_wr[50] = 1; s_addr[50] = TOHOST; s_data[50] = 32'h7;
        for (int j = 0; j < 30; j++) s_busy[j] = 1;
        do_run("fail_busy", -1);

        do_reset(); clear_stim();
        for (int k = 0; k < MAXC; k++) begin
            s_chen[k] = 2'b11; s_kick[k] = {1'b0, (k % 8 == 0)};
        end
        do_run("watchdog", -1);

        do_reset(); clear_stim();
        for (int k = 0; k < MAXC; k++) begin
            s_chen[k] = 2'b01; s_kick[k] = {1'b0, (k % 8 == 0)};
        end
        s_halt[40] = 1;
        do_run("wd_ch1_off", -1);

        do_reset(); clear_stim();
        s_trap[5] = 1; s_halt[5] = 1; s_wr[5] = 1; s_addr[5] = TOHOST; s_data[5] = 32'h1;
        do_run("simul_trap", -1);

        do_reset(); clear_stim();
        s_halt[5] = 1; s_wr[5] = 1; s_addr[5] = TOHOST; s_data[5] = 32'h9;
        do_run("simul_tohost", -1);

        do_reset(); clear_stim();
        s_wr[3] = 1; s_addr[3] = TOHOST; s_data[3] = 32'h6;
        s_wr[4] = 1; s_addr[4] = TOHOST + 32'h4; s_data[4] = 32'h3;
        s_halt[6] = 1;
        do_run("tohost_ignored", -1);

        do_reset(); clear_stim();
        s_halt[3] = 1;
        for (int j = 0; j < DMAX; j++) s_busy[j] = 1;
        do_run("drain_cap", -1);

        do_reset(); clear_stim();
        s_halt[10] = 1;
        do_run("rst_drain", 5);
        clear_stim();
        s_halt[20] = 1;
        do_run("fresh_after_rst", -1);

        do_reset(); clear_stim();
        s_halt[300] = 1;
        do_run("cycles_sat", -1);

        for (int r = 0; r < 25; r++) begin
            do_reset();
            gen_random();
            do_run("rand", ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 10)) : -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
